// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scanner FSM states, key-code constants and the
// row/column to key-code map used by both the scanner and the calculator.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HOLD      = 2'd2
  } kp_state_e;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = KEY_1;
      4'd1:    code = KEY_2;
      4'd2:    code = KEY_3;
      4'd3:    code = KEY_A;
      4'd4:    code = KEY_4;
      4'd5:    code = KEY_5;
      4'd6:    code = KEY_6;
      4'd7:    code = KEY_B;
      4'd8:    code = KEY_7;
      4'd9:    code = KEY_8;
      4'd10:   code = KEY_9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = KEY_0;
      4'd14:   code = KEY_HASH;
      4'd15:   code = KEY_D;
      default: code = KEY_0;
    endcase
    return code;
  endfunction

  // Exactly one active-low line asserted; anything else is idle or a multi-key chord.
  function automatic logic one_low(input logic [3:0] v);
    logic res;
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Free-running scan-rate divider: one-cycle tick every SCAN_DIV clocks.
module scan_tick_gen #(
  parameter int SCAN_DIV = 10000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Registered tick is high while the counter sits at its last value.
  always_comb begin
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = (cnt_q == CW'(SCAN_DIV - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, column synchronisation, press and
// release debouncing, and key-code strobe generation.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 10000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] keypad_out,
  output logic       key_pressed,
  output logic       key_held
);

  localparam int             DW       = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0]  CNT_LAST = DW'(DEBOUNCE_TICKS - 1);

  logic            tick;
  logic [3:0]      sync1_q, col_s_q;
  kp_state_e       state_q, state_d;
  logic [3:0]      row_q, row_d;
  logic [1:0]      cand_q, cand_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [3:0]      code_q, code_d;
  logic            strobe_q, strobe_d;
  logic            held_q, held_d;

  logic            col_valid;
  logic [1:0]      col_idx;
  logic [1:0]      row_idx;
  logic [3:0]      row_next;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign col_valid = one_low(col_s_q);
  assign col_idx   = low_index(col_s_q);
  assign row_idx   = low_index(row_q);
  assign row_next  = {row_q[2:0], row_q[3]};

  // Next-state logic; every decision is taken only on a scan tick.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    strobe_d = 1'b0;
    held_d   = held_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (col_valid) begin
            cand_d  = col_idx;
            cnt_d   = DW'(1);
            state_d = DEB_PRESS;
          end else begin
            row_d = row_next;
          end
        end
        DEB_PRESS: begin
          if (col_valid && (col_idx == cand_q)) begin
            if (cnt_q >= CNT_LAST) begin
              code_d   = key_code(row_idx, cand_q);
              strobe_d = 1'b1;
              held_d   = 1'b1;
              cnt_d    = '0;
              state_d  = HOLD;
            end else begin
              cnt_d = cnt_q + DW'(1);
            end
          end else begin
            cnt_d   = '0;
            row_d   = row_next;
            state_d = SCAN;
          end
        end
        HOLD: begin
          // Only the latched column on the frozen row decides release.
          if (col_s_q[cand_q]) begin
            if (cnt_q >= CNT_LAST) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              row_d   = row_next;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_q + DW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d   = '0;
          held_d  = 1'b0;
          state_d = SCAN;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 4'hF;
      col_s_q  <= 4'hF;
      state_q  <= SCAN;
      row_q    <= 4'b1110;
      cand_q   <= 2'd0;
      cnt_q    <= '0;
      code_q   <= 4'h0;
      strobe_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      sync1_q  <= col_in;
      col_s_q  <= sync1_q;
      state_q  <= state_d;
      row_q    <= row_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
    end
  end

  assign row_out     = row_q;
  assign keypad_out  = code_q;
  assign key_pressed = strobe_q;
  assign key_held    = held_q;

endmodule
